// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - HH:MM:SS time-setting front end: key debounce, edit FSM, load pulse, blink mask
//
// Debounces the mode/inc/ok push-buttons and runs the edit state machine that
// steps through the hours, minutes and seconds fields of the clock. On ok it
// emits a one-cycle load pulse carrying the edited BCD time.
//
// Optional feature macro: TSET_BLINK_EN builds the blink counter that drives
// blink_mask. Without it blink_mask is tied to zero.
//
// Parameters:
//   DB_CNT     - debounce stable time in clk cycles
//   BLINK_CNT  - blink half-period in clk cycles
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   key_mode, key_inc, key_ok   - raw active-low buttons, asynchronous to clk
//   cur_hh_t .. cur_ss_u        - running time, BCD
//   set_hh_t .. set_ss_u        - edited time, BCD, registered
//   set_load                    - one-cycle pulse: clock block loads set_*
//   editing                     - high in any edit state (clock block holds)
//   blink_mask                  - per-digit blank request, [5:4] hh, [3:2] mm, [1:0] ss
module time_set_ctrl #(
  parameter int DB_CNT    = 1_000_000,
  parameter int BLINK_CNT = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_ok,
  input  logic [1:0] cur_hh_t,
  input  logic [3:0] cur_hh_u,
  input  logic [2:0] cur_mm_t,
  input  logic [3:0] cur_mm_u,
  input  logic [2:0] cur_ss_t,
  input  logic [3:0] cur_ss_u,
  output logic [1:0] set_hh_t,
  output logic [3:0] set_hh_u,
  output logic [2:0] set_mm_t,
  output logic [3:0] set_mm_u,
  output logic [2:0] set_ss_t,
  output logic [3:0] set_ss_u,
  output logic       set_load,
  output logic       editing,
  output logic [5:0] blink_mask
);

  localparam int DBW = $clog2(DB_CNT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EDIT_HH = 2'd1,
    EDIT_MM = 2'd2,
    EDIT_SS = 2'd3
  } state_t;

  state_t state;

  // Key index: 0 = inc, 1 = mode, 2 = ok
  logic [2:0]          raw_keys;
  logic [2:0]          sync1;
  logic [2:0]          sync2;
  logic [2:0]          db_level;
  logic [2:0]          db_level_q;
  logic [2:0]          press;
  logic [2:0][DBW-1:0] db_cnt;

  assign raw_keys = {key_ok, key_mode, key_inc};

  // The counter only runs while the synced input disagrees with the
  // debounced level, so any bounce back to the old level restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '1;
      sync2      <= '1;
      db_level   <= '1;
      db_level_q <= '1;
      press      <= '0;
      db_cnt     <= '0;
    end else begin
      sync1      <= raw_keys;
      sync2      <= sync1;
      db_level_q <= db_level;
      press      <= db_level_q & ~db_level;
      for (int k = 0; k < 3; k++) begin
        if (sync2[k] == db_level[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DBW'(DB_CNT - 1)) begin
          db_level[k] <= sync2[k];
          db_cnt[k]   <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + 1'b1;
        end
      end
    end
  end

  logic p_inc, p_mode, p_ok;
  assign p_inc  = press[0];
  assign p_mode = press[1];
  assign p_ok   = press[2];

  // ok is ignored in IDLE, so it only masks mode once editing.
  logic edit_entry;
  assign edit_entry = p_mode & ((state == IDLE) | ~p_ok);

  function automatic logic [5:0] clamp_hh(input logic [1:0] t, input logic [3:0] u);
    if (t > 2'd2 || u > 4'd9 || (t == 2'd2 && u > 4'd3))
      return {2'd2, 4'd3};
    return {t, u};
  endfunction

  function automatic logic [6:0] clamp_ms(input logic [2:0] t, input logic [3:0] u);
    if (t > 3'd5 || u > 4'd9)
      return {3'd5, 4'd9};
    return {t, u};
  endfunction

  function automatic logic [5:0] inc_hh(input logic [1:0] t, input logic [3:0] u);
    if (t == 2'd2 && u == 4'd3)
      return 6'd0;
    if (u == 4'd9)
      return {t + 2'd1, 4'd0};
    return {t, u + 4'd1};
  endfunction

  function automatic logic [6:0] inc_ms(input logic [2:0] t, input logic [3:0] u);
    if (u == 4'd9)
      return (t == 3'd5) ? 7'd0 : {t + 3'd1, 4'd0};
    return {t, u + 4'd1};
  endfunction

  // Edit registers are the set_* outputs themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      set_hh_t <= '0;
      set_hh_u <= '0;
      set_mm_t <= '0;
      set_mm_u <= '0;
      set_ss_t <= '0;
      set_ss_u <= '0;
      set_load <= 1'b0;
      editing  <= 1'b0;
    end else begin
      set_load <= 1'b0;
      if (state == IDLE) begin
        if (p_mode) begin
          {set_hh_t, set_hh_u} <= clamp_hh(cur_hh_t, cur_hh_u);
          {set_mm_t, set_mm_u} <= clamp_ms(cur_mm_t, cur_mm_u);
          {set_ss_t, set_ss_u} <= clamp_ms(cur_ss_t, cur_ss_u);
          state                <= EDIT_HH;
          editing              <= 1'b1;
        end
      end else if (p_ok) begin
        set_load <= 1'b1;
        editing  <= 1'b0;
        state    <= IDLE;
      end else if (p_mode) begin
        case (state)
          EDIT_HH: state <= EDIT_MM;
          EDIT_MM: state <= EDIT_SS;
          default: state <= EDIT_HH;
        endcase
      end else if (p_inc) begin
        case (state)
          EDIT_HH: {set_hh_t, set_hh_u} <= inc_hh(set_hh_t, set_hh_u);
          EDIT_MM: {set_mm_t, set_mm_u} <= inc_ms(set_mm_t, set_mm_u);
          default: {set_ss_t, set_ss_u} <= inc_ms(set_ss_t, set_ss_u);
        endcase
      end
    end
  end

`ifdef TSET_BLINK_EN
  localparam int BLW = $clog2(BLINK_CNT + 1);

  logic [BLW-1:0] blink_cnt;
  logic           blink_phase;

  // Restarting on every field change gives the newly selected field a full
  // visible half-period before it first blanks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (edit_entry) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLW'(BLINK_CNT - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    blink_mask = '0;
    case (state)
      EDIT_HH: blink_mask[5:4] = {2{blink_phase}};
      EDIT_MM: blink_mask[3:2] = {2{blink_phase}};
      EDIT_SS: blink_mask[1:0] = {2{blink_phase}};
      default: blink_mask = '0;
    endcase
  end
`else
  logic blink_unused;
  assign blink_unused = edit_entry & (BLINK_CNT != 0);
  assign blink_mask   = '0;
`endif

endmodule
